// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream, assembles 15-bit instruction
// words, writes them to instruction memory and gates the CPU around the load.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [14:0] im_wdata,
  output logic        cpu_run,
  output logic        cpu_rst,
  output logic        busy,
  output logic        error,
  output logic [8:0]  words_loaded
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_RUN, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic          in_ready_nxt, im_we_nxt, cpu_run_nxt, cpu_rst_nxt;
  logic          busy_nxt, error_nxt;
  logic [7:0]    addr, addr_nxt;
  logic [14:0]   im_wdata_nxt;
  logic [8:0]    words_loaded_nxt;
  logic [8:0]    total, total_nxt;
  logic [7:0]    checksum, checksum_nxt;
  logic [6:0]    hi_byte, hi_byte_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          accept, in_frame;

  assign accept   = in_valid && in_ready;
  assign in_frame = (state == S_COUNT) || (state == S_HI) ||
                    (state == S_LO)    || (state == S_CHECK);
  assign im_addr  = addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      addr         <= 8'd0;
      im_wdata     <= 15'd0;
      cpu_run      <= 1'b0;
      cpu_rst      <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 9'd0;
      total        <= 9'd0;
      checksum     <= 8'd0;
      hi_byte      <= 7'd0;
      tmo_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      in_ready     <= in_ready_nxt;
      im_we        <= im_we_nxt;
      addr         <= addr_nxt;
      im_wdata     <= im_wdata_nxt;
      cpu_run      <= cpu_run_nxt;
      cpu_rst      <= cpu_rst_nxt;
      busy         <= busy_nxt;
      error        <= error_nxt;
      words_loaded <= words_loaded_nxt;
      total        <= total_nxt;
      checksum     <= checksum_nxt;
      hi_byte      <= hi_byte_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    in_ready_nxt     = 1'b1;
    im_we_nxt        = 1'b0;
    cpu_rst_nxt      = 1'b0;
    im_wdata_nxt     = im_wdata;
    cpu_run_nxt      = cpu_run;
    busy_nxt         = busy;
    error_nxt        = error;
    words_loaded_nxt = words_loaded;
    total_nxt        = total;
    checksum_nxt     = checksum;
    hi_byte_nxt      = hi_byte;
    // The write index advances in the cycle the word is presented.
    addr_nxt         = im_we ? addr + 8'd1 : addr;
    tmo_cnt_nxt      = (in_frame && !accept) ? tmo_cnt + 1'b1 : '0;

    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_nxt        = S_COUNT;
          cpu_run_nxt      = 1'b0;
          error_nxt        = 1'b0;
          busy_nxt         = 1'b1;
          addr_nxt         = 8'd0;
          checksum_nxt     = 8'd0;
          words_loaded_nxt = 9'd0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          total_nxt    = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          checksum_nxt = in_data;
          state_nxt    = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          if (in_data[7]) begin
            state_nxt = S_ERR;
            error_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            hi_byte_nxt  = in_data[6:0];
            checksum_nxt = checksum ^ in_data;
            state_nxt    = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          im_we_nxt        = 1'b1;
          im_wdata_nxt     = {hi_byte, in_data};
          checksum_nxt     = checksum ^ in_data;
          words_loaded_nxt = words_loaded + 9'd1;
          state_nxt        = (words_loaded + 9'd1 == total) ? S_CHECK : S_HI;
        end
      end
      S_CHECK: begin
        if (accept) begin
          busy_nxt = 1'b0;
          if (in_data == checksum) begin
            state_nxt   = S_RUN;
            cpu_run_nxt = 1'b1;
            cpu_rst_nxt = 1'b1;
          end else begin
            state_nxt = S_ERR;
            error_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort lands on the edge where the idle count would reach TIMEOUT.
    if (in_frame && !accept && tmo_cnt == TW'(TIMEOUT - 1)) begin
      state_nxt   = S_ERR;
      error_nxt   = 1'b1;
      busy_nxt    = 1'b0;
      tmo_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: framing, checksum, errors,
// full 256-word image, timeout and reset behaviour.
module tb_prog_loader;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic        cpu_run;
  logic        cpu_rst;
  logic        busy;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int rst_pulses = 0;

  logic [7:0]  wr_addr[$];
  logic [14:0] wr_data[$];

  prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_run(cpu_run), .cpu_rst(cpu_rst), .busy(busy), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Log memory writes and restart pulses away from the active edge.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
    if (cpu_rst === 1'b1) rst_pulses++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          bad;
    int          base_pulses;
    logic [7:0]  chk;
    logic [14:0] exp_w;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(3);
    check_output("rst_ready", in_ready, 0);
    check_output("rst_outs", {im_we, im_addr, im_wdata, cpu_run, cpu_rst, busy, error},
                 0);
    check_output("rst_words", words_loaded, 0);

    // Sync offered while in_ready is still low must not be consumed.
    rst_n    = 1'b1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("ready_up", in_ready, 1);
    check_output("not_consumed", busy, 0);

    // Good frame
    wr_addr.delete(); wr_data.delete();
    apply_byte(8'hA5);
    check_output("sync_busy", busy, 1);
    apply_byte(8'h02);
    apply_byte(8'h01);
    apply_byte(8'h23);
    check_output("w0_we", im_we, 1);
    check_output("w0_addr", im_addr, 8'h00);
    check_output("w0_data", im_wdata, 15'h0123);
    apply_byte(8'h7F);
    check_output("w_gap", im_we, 0);
    apply_byte(8'hFF);
    check_output("w1_addr", im_addr, 8'h01);
    check_output("w1_data", im_wdata, 15'h7FFF);
    apply_byte(8'hA0);
    check_output("good_rst", cpu_rst, 1);
    check_output("good_run", cpu_run, 1);
    check_output("good_busy", busy, 0);
    idle(1);
    check_output("good_rst_pulse", cpu_rst, 0);
    check_output("good_run_hold", cpu_run, 1);
    check_output("good_words", words_loaded, 2);
    check_output("good_err", error, 0);
    check_output("good_nwr", wr_addr.size(), 2);
    check_output("good_pulses", rst_pulses, 1);

    // Resync out of RUN, then bad checksum
    wr_addr.delete(); wr_data.delete();
    base_pulses = rst_pulses;
    apply_byte(8'hA5);
    check_output("resync_run", cpu_run, 0);
    check_output("resync_busy", busy, 1);
    apply_byte(8'h02);
    apply_byte(8'h01);
    apply_byte(8'h23);
    apply_byte(8'h7F);
    apply_byte(8'hFF);
    apply_byte(8'hA1);
    check_output("badchk_err", error, 1);
    check_output("badchk_run", cpu_run, 0);
    check_output("badchk_busy", busy, 0);
    idle(2);
    check_output("badchk_nwr", wr_addr.size(), 2);
    check_output("badchk_pulses", rst_pulses, base_pulses);
    check_output("badchk_err_sticky", error, 1);

    // A fresh sync clears the error; then an illegal HI byte
    wr_addr.delete(); wr_data.delete();
    apply_byte(8'hA5);
    check_output("err_clear", error, 0);
    apply_byte(8'h01);
    apply_byte(8'h80);
    check_output("illhi_err", error, 1);
    check_output("illhi_busy", busy, 0);
    idle(2);
    check_output("illhi_nwr", wr_addr.size(), 0);

    // Full 256-word image
    wr_addr.delete(); wr_data.delete();
    apply_byte(8'hA5);
    apply_byte(8'h00);
    chk = 8'h00;
    for (int i = 0; i < 256; i++) begin
      apply_byte(8'(i & 8'h7F));
      apply_byte(8'(i));
      chk = chk ^ 8'(i & 8'h7F) ^ 8'(i);
    end
    check_output("full_last_addr", im_addr, 8'hFF);
    check_output("full_last_we", im_we, 1);
    apply_byte(chk);
    check_output("full_wrap", im_addr, 8'h00);
    check_output("full_words", words_loaded, 256);
    check_output("full_run", cpu_run, 1);
    check_output("full_nwr", wr_addr.size(), 256);
    bad = 0;
    if (wr_addr.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        exp_w = {7'(i & 32'h7F), 8'(i)};
        if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_w) bad++;
      end
    end else begin
      bad = 1;
    end
    check_output("full_order", bad, 0);

    // Timeout, then reload
    apply_byte(8'hA5);
    apply_byte(8'h01);
    apply_byte(8'h05);
    idle(TMO - 1);
    check_output("tmo_early", error, 0);
    check_output("tmo_early_busy", busy, 1);
    idle(1);
    check_output("tmo_err", error, 1);
    check_output("tmo_busy", busy, 0);
    wr_addr.delete(); wr_data.delete();
    apply_byte(8'hA5);
    apply_byte(8'h01);
    apply_byte(8'h03);
    apply_byte(8'h45);
    apply_byte(8'h47);
    check_output("reload_run", cpu_run, 1);
    check_output("reload_err", error, 0);
    check_output("reload_words", words_loaded, 1);
    check_output("reload_data", (wr_data.size() == 1) ? 32'(wr_data[0]) : 32'hDEAD,
                 15'h0345);

    // Reset mid-frame after the HI byte
    wr_addr.delete(); wr_data.delete();
    apply_byte(8'hA5);
    apply_byte(8'h01);
    apply_byte(8'h12);
    rst_n = 1'b0;
    apply_byte(8'h34);
    check_output("midrst_outs",
                 {in_ready, im_we, im_addr, im_wdata, cpu_run, cpu_rst, busy, error}, 0);
    check_output("midrst_words", words_loaded, 0);
    rst_n = 1'b1;
    idle(1);
    apply_byte(8'h34);
    check_output("midrst_idle", busy, 0);
    idle(1);
    check_output("midrst_nwr", wr_addr.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
